// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single data port (port B) of the on-chip RAM between N_REQ bus
// masters. Requester 0 is the CPU; the rest are DMA / debug loaders.
// Arbitration is round-robin with a same-cycle combinational grant. A granted
// requester can take a lock so that an atomic read-modify-write sequence is
// not interleaved with other masters. A watchdog force-releases a lock held
// for too long. Read data from the RAM (1-cycle latency) is steered back to
// the requester that issued the read.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   req_i        per-requester access request (level, held until granted)
//   lock_i       per-requester lock request, meaningful while granted
//   we_i         per-requester byte enables, requester k at [4k+3:4k]
//   addr_i       per-requester byte address, requester k at [32k+31:32k]
//   wdata_i      per-requester write data, requester k at [32k+31:32k]
//   gnt_o        one-hot grant, combinational, same cycle as the request
//   rvalid_o     one-hot read-data-valid, one cycle after a granted read
//   rdata_o      read data, qualified by rvalid_o
//   lock_err_o   one-cycle pulse when a lock is force-released by timeout
//   mem_en_o     RAM port enable
//   mem_we_o     RAM byte write enables
//   mem_addr_o   RAM byte address
//   mem_wdata_o  RAM write data
//   mem_rdata_i  RAM read data, valid one cycle after mem_en_o
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    lock_i,
    input  logic [N_REQ*4-1:0]  we_i,
    input  logic [N_REQ*32-1:0] addr_i,
    input  logic [N_REQ*32-1:0] wdata_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                lock_err_o,
    output logic                mem_en_o,
    output logic [3:0]          mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_lockCnt;
    logic               r_blockValid;
    logic [PTR_W-1:0]   r_blockIdx;
    logic [N_REQ-1:0]   r_rvalid;
    logic               r_lockErr;

    logic [N_REQ-1:0]   w_gnt;
    logic               w_gntAny;
    logic [PTR_W-1:0]   w_gntIdx;
    logic               w_isRead;
    logic               w_lockBlocked;

    // Successor of a requester index in round-robin order, wrapping at N_REQ
    // (N_REQ need not be a power of two, so plain overflow is not enough).
    function automatic logic [PTR_W-1:0] incIdx(input logic [PTR_W-1:0] idx);
        int nxt;
        nxt = (int'(idx) + 1) % N_REQ;
        return PTR_W'(nxt);
    endfunction

    // Grant selection. While locked only the owner can be granted, and only
    // when it is actually requesting. Otherwise scan from the round-robin
    // pointer and take the first active request. Reset forces no grant so the
    // RAM port stays idle while the arbiter is being cleared.
    always_comb begin : grantSelect
        int scan;
        scan     = 0;
        w_gnt    = '0;
        w_gntAny = 1'b0;
        w_gntIdx = '0;
        if (!reset) begin
            if (r_state == ST_LOCKED) begin
                if (req_i[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    w_gntAny       = 1'b1;
                    w_gntIdx       = r_owner;
                end
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    scan = (int'(r_ptr) + i) % N_REQ;
                    if (!w_gntAny && req_i[PTR_W'(scan)]) begin
                        w_gnt[PTR_W'(scan)] = 1'b1;
                        w_gntAny            = 1'b1;
                        w_gntIdx            = PTR_W'(scan);
                    end
                end
            end
        end
    end

    // RAM port mux driven from the one-hot grant. With no grant the port is
    // disabled and address/data are held at zero to keep the bus quiet.
    always_comb begin : portMux
        mem_en_o    = w_gntAny;
        mem_we_o    = 4'b0000;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                mem_we_o    = we_i[4*k +: 4];
                mem_addr_o  = addr_i[32*k +: 32];
                mem_wdata_o = wdata_i[32*k +: 32];
            end
        end
    end

    assign w_isRead      = w_gntAny && (mem_we_o == 4'b0000);
    assign w_lockBlocked = r_blockValid && (r_blockIdx == w_gntIdx);

    assign gnt_o      = w_gnt;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = mem_rdata_i;
    assign lock_err_o = r_lockErr;

    // Arbiter state machine plus the registered outputs.
    // The read-valid vector is the grant of a read delayed by one cycle,
    // matching the RAM latency, so data always returns to the issuer.
    // After a watchdog release the old owner is remembered as blocked: its
    // still-asserted lock_i must not re-lock until it has been dropped once,
    // otherwise a stuck master would simply re-acquire the bus forever.
    // Leaving LOCKED (voluntarily or forced) moves the pointer past the owner
    // so the waiting masters get the next turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_UNLOCKED;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_lockCnt    <= '0;
            r_blockValid <= 1'b0;
            r_blockIdx   <= '0;
            r_rvalid     <= '0;
            r_lockErr    <= 1'b0;
        end else begin
            r_rvalid  <= w_isRead ? w_gnt : '0;
            r_lockErr <= 1'b0;
            if (r_blockValid && !lock_i[r_blockIdx]) begin
                r_blockValid <= 1'b0;
            end
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_gntAny) begin
                        r_ptr <= incIdx(w_gntIdx);
                        if (lock_i[w_gntIdx] && !w_lockBlocked) begin
                            r_state   <= ST_LOCKED;
                            r_owner   <= w_gntIdx;
                            r_lockCnt <= CNT_ONE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!lock_i[r_owner]) begin
                        r_state   <= ST_UNLOCKED;
                        r_ptr     <= incIdx(r_owner);
                        r_lockCnt <= '0;
                    end else if (r_lockCnt == CNT_MAX) begin
                        r_state      <= ST_UNLOCKED;
                        r_ptr        <= incIdx(r_owner);
                        r_lockCnt    <= '0;
                        r_lockErr    <= 1'b1;
                        r_blockValid <= 1'b1;
                        r_blockIdx   <= r_owner;
                    end else begin
                        r_lockCnt <= r_lockCnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_UNLOCKED;
                end
            endcase
        end
    end

endmodule
